// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_pkg
// Purpose  : Shared SCCB definitions for the config sequencer, the master and
//            the master arbiter. It holds the arbiter state encoding, the
//            read/write flag values and the SCCB byte width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    localparam int   SCCB_BYTE_W   = 8;
    localparam logic SCCB_RW_READ  = 1'b1;
    localparam logic SCCB_RW_WRITE = 1'b0;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_START = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_RESP  = 5'b01000,
        ST_ERR   = 5'b10000
    } sccb_state_t;

endpackage : sccb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. The search starts at index ptr and
//            wraps. The first active request wins.
// Ports    : req     - request vector
//            ptr     - index that has highest priority this round (< N)
//            gnt     - one-hot winner (all zero when no request)
//            gnt_idx - binary index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index (ptr + i) mod N. The extra bit absorbs the carry
            // before the wrap.
            w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sccb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sccb_master_arbiter
// Purpose  : Shares one SCCB master between NUM_REQ requesters.
//            - Grant is round-robin. The winner's command is latched.
//            - The arbiter runs the start/done handshake with the master.
//            - It returns done, rd_data and err to the winner.
//            - A watchdog aborts any phase that exceeds TIMEOUT_US.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/rw/devaddr/
//            regaddr/wrdata             - per-requester command (byte lanes)
//            req_grant/done/err         - one-hot single-cycle status pulses
//            rd_data                    - read result, held until next read
//            sccb_start/rw/devaddr/
//            regaddr/wrdata             - command to the SCCB master
//            sccb_rddata, sccb_done     - master read data and idle status
//            busy                       - arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module sccb_master_arbiter
    import sccb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int TIMEOUT_US    = 2000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [SCCB_BYTE_W*NUM_REQ-1:0] req_devaddr,
    input  logic [SCCB_BYTE_W*NUM_REQ-1:0] req_regaddr,
    input  logic [SCCB_BYTE_W*NUM_REQ-1:0] req_wrdata,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_err,
    output logic [SCCB_BYTE_W-1:0]         rd_data,
    output logic                           sccb_start,
    output logic                           sccb_rw,
    output logic [SCCB_BYTE_W-1:0]         devaddr,
    output logic [SCCB_BYTE_W-1:0]         regaddr,
    output logic [SCCB_BYTE_W-1:0]         wrdata,
    input  logic [SCCB_BYTE_W-1:0]         sccb_rddata,
    input  logic                           sccb_done,
    output logic                           busy
);

    localparam int TIMEOUT_CYC = TIMEOUT_US * (CLK_FREQUENCE / 1_000_000);
    localparam int WDOG_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sccb_state_t             r_state, w_next;
    logic [IDX_W-1:0]        r_ptr, r_idx, w_gnt_idx, w_ptr_next;
    logic [NUM_REQ-1:0]      w_gnt, r_grant, w_owner;
    logic [WDOG_W-1:0]       r_wdog;
    logic                    w_wdog_exp, w_accept;
    logic                    r_rw, w_rw;
    logic [SCCB_BYTE_W-1:0]  r_devaddr, r_regaddr, r_wrdata, r_rd_data;
    logic [SCCB_BYTE_W-1:0]  w_devaddr, w_regaddr, w_wrdata;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Select the winner's command fields with a one-hot OR mux.
    always_comb begin
        w_rw      = SCCB_RW_WRITE;
        w_devaddr = '0;
        w_regaddr = '0;
        w_wrdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_rw      = req_rw[i];
                w_devaddr = req_devaddr[SCCB_BYTE_W*i +: SCCB_BYTE_W];
                w_regaddr = req_regaddr[SCCB_BYTE_W*i +: SCCB_BYTE_W];
                w_wrdata  = req_wrdata [SCCB_BYTE_W*i +: SCCB_BYTE_W];
            end
        end
    end

    // A low sccb_done while idle means the master is busy with something else,
    // so hold off granting.
    assign w_accept   = (r_state == ST_IDLE) && (|req_valid) && sccb_done;
    assign w_wdog_exp = (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_owner    = NUM_REQ'(1) << r_idx;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept)   w_next = ST_START;
            // The master acknowledging start wins over a simultaneous timeout.
            ST_START: if (!sccb_done) w_next = ST_WAIT;
                      else if (w_wdog_exp) w_next = ST_ERR;
            ST_WAIT:  if (sccb_done)  w_next = ST_RESP;
                      else if (w_wdog_exp) w_next = ST_ERR;
            ST_RESP:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_rw      <= SCCB_RW_WRITE;
            r_devaddr <= '0;
            r_regaddr <= '0;
            r_wrdata  <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= w_accept ? w_gnt : '0;

            if (w_accept) begin
                r_idx     <= w_gnt_idx;
                r_rw      <= w_rw;
                r_devaddr <= w_devaddr;
                r_regaddr <= w_regaddr;
                r_wrdata  <= w_wrdata;
            end

            if (r_state == ST_WAIT && sccb_done && r_rw == SCCB_RW_READ) begin
                r_rd_data <= sccb_rddata;
            end

            if (r_state == ST_RESP || r_state == ST_ERR) begin
                r_ptr <= w_ptr_next;
            end

            if (w_next != r_state) begin
                r_wdog <= '0;
            end else if (r_state == ST_START || r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end

    // Status pulses decode directly from state. An asynchronous reset
    // therefore removes sccb_start and all pulses at once.
    assign sccb_start = (r_state == ST_START);
    assign busy       = (r_state != ST_IDLE);
    assign req_grant  = r_grant;
    assign req_done   = (r_state == ST_RESP) ? w_owner : '0;
    assign req_err    = (r_state == ST_ERR)  ? w_owner : '0;
    assign rd_data    = r_rd_data;
    assign sccb_rw    = r_rw;
    assign devaddr    = r_devaddr;
    assign regaddr    = r_regaddr;
    assign wrdata     = r_wrdata;

endmodule : sccb_master_arbiter
`default_nettype wire

// File: tb/tb_sccb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_master_arbiter
// Purpose  : Self-checking bench for sccb_master_arbiter with NUM_REQ=2 and
//            TIMEOUT_CYC=100. A behavioural SCCB master model answers
//            sccb_start. Expected grants are queued when a request is driven
//            and are popped when the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_master_arbiter;

    localparam int NREQ  = 2;
    localparam int DROP  = 3;   // model: cycles from seeing start to dropping done
    localparam int BUSY  = 50;  // model: cycles done is held low
    localparam int TOUT  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [8*NREQ-1:0] req_devaddr = '0;
    logic [8*NREQ-1:0] req_regaddr = '0;
    logic [8*NREQ-1:0] req_wrdata = '0;
    logic [NREQ-1:0]   req_grant, req_done, req_err;
    logic [7:0]        rd_data, devaddr, regaddr, wrdata;
    logic              sccb_start, sccb_rw, busy;
    logic [7:0]        sccb_rddata = '0;
    logic              sccb_done = 1'b1;

    int total = 0;
    int bad   = 0;

    // Master model controls
    logic       model_hang = 1'b0;
    logic       force_low  = 1'b0;
    logic [7:0] model_rd   = '0;
    logic       m_done     = 1'b1;
    int         m_phase    = 0;
    int         m_cnt      = 0;

    typedef struct {
        int         idx;
        logic       rw;
        logic [7:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
        logic [7:0] rd;
    } exp_t;
    exp_t exp_q[$];

    sccb_master_arbiter #(
        .NUM_REQ       (NREQ),
        .CLK_FREQUENCE (50_000_000),
        .TIMEOUT_US    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_devaddr (req_devaddr),
        .req_regaddr (req_regaddr),
        .req_wrdata  (req_wrdata),
        .req_grant   (req_grant),
        .req_done    (req_done),
        .req_err     (req_err),
        .rd_data     (rd_data),
        .sccb_start  (sccb_start),
        .sccb_rw     (sccb_rw),
        .devaddr     (devaddr),
        .regaddr     (regaddr),
        .wrdata      (wrdata),
        .sccb_rddata (sccb_rddata),
        .sccb_done   (sccb_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SCCB master. It updates on the falling edge, away from the
    // DUT's active edge.
    always @(negedge clk) begin
        case (m_phase)
            0: if (sccb_start && !model_hang) begin
                   m_cnt   = DROP;
                   m_phase = 1;
               end
            1: if (m_cnt <= 1) begin
                   m_done  = 1'b0;
                   m_cnt   = BUSY;
                   m_phase = 2;
               end else m_cnt--;
            default: if (m_cnt <= 1) begin
                   m_done      = 1'b1;
                   sccb_rddata = model_rd;
                   m_phase     = 0;
               end else m_cnt--;
        endcase
        sccb_done = m_done && !force_low;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant pulse (which=0) or a done/err pulse (which=1).
    // This is bounded by budget. ngrant counts grants seen while waiting.
    task automatic wait_pulse(input int which, input int budget,
                              output int cyc, output int ngrant);
        bit hit;
        cyc = 0; ngrant = 0; hit = 0;
        while (!hit && cyc < budget) begin
            tick();
            cyc++;
            if (req_grant != 0) ngrant++;
            hit = (which == 0) ? (req_grant != 0) : ((req_done | req_err) != 0);
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [7:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
        req_rw[i]            = rw;
        req_devaddr[8*i +: 8] = dev;
        req_regaddr[8*i +: 8] = ra;
        req_wrdata[8*i +: 8]  = wd;
    endtask

    task automatic push_exp(input int i, input logic rw, input logic [7:0] dev,
                            input logic [7:0] ra, input logic [7:0] wd,
                            input logic [7:0] rd);
        exp_t e;
        e.idx = i; e.rw = rw; e.dev = dev; e.ra = ra; e.wd = wd; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (sccb_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", sccb_start); end
        total++; if ((req_grant | req_done | req_err) !== 2'b00)
                 begin bad++; $display("FAIL reset_pulses got=%b/%b/%b exp=0", req_grant, req_done, req_err); end
        total++; if ({rd_data, devaddr, regaddr, wrdata, sccb_rw} !== 33'd0)
                 begin bad++; $display("FAIL reset_outputs rd=%h dev=%h reg=%h wd=%h rw=%b exp=0", rd_data, devaddr, regaddr, wrdata, sccb_rw); end
    endtask

    task automatic test_write();
        int cyc, ng, lat;
        exp_t e;
        set_req(0, 1'b0, 8'h60, 8'h12, 8'h80);
        push_exp(0, 1'b0, 8'h60, 8'h12, 8'h80, 8'h00);
        req_valid = 2'b01;
        wait_pulse(0, 20, cyc, ng);
        e = exp_q.pop_front();
        total++; if (req_grant !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b exp=01", req_grant); end
        total++; if ({devaddr, regaddr, wrdata, sccb_rw} !== {e.dev, e.ra, e.wd, e.rw})
                 begin bad++; $display("FAIL wr_fields got=%h/%h/%h/%b exp=%h/%h/%h/%b", devaddr, regaddr, wrdata, sccb_rw, e.dev, e.ra, e.wd, e.rw); end
        wait_pulse(1, 300, lat, ng);
        req_valid = 2'b00;
        total++; if (req_done !== 2'b01 || req_err !== 2'b00)
                 begin bad++; $display("FAIL wr_done got=%b err=%b exp=01", req_done, req_err); end
        total++; if (ng !== 0) begin bad++; $display("FAIL wr_single_grant extra=%0d exp=0", ng); end
        // START lasts DROP+1 cycles and WAIT lasts BUSY cycles. done is
        // reported in the following RESP cycle.
        total++; if (lat !== DROP + BUSY + 1) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, DROP + BUSY + 1); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL wr_rd_untouched got=%h exp=00", rd_data); end
    endtask

    task automatic test_round_robin();
        int cyc, ng, prev, obs;
        exp_t e;
        do_reset();
        model_rd = 8'h5A;
        set_req(0, 1'b0, 8'h42, 8'h01, 8'h11);
        set_req(1, 1'b1, 8'h43, 8'h02, 8'h00);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(0, 1'b0, 8'h42, 8'h01, 8'h11, 8'h00);
            else            push_exp(1, 1'b1, 8'h43, 8'h02, 8'h00, 8'h5A);
        end
        req_valid = 2'b11;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(0, 300, cyc, ng);
            e = exp_q.pop_front();
            obs = req_grant[1] ? 1 : 0;
            total++; if (req_grant !== 2'(1 << e.idx))
                     begin bad++; $display("FAIL rr_order_%0d got=%b exp=%b", k, req_grant, 2'(1 << e.idx)); end
            total++; if (obs == prev) begin bad++; $display("FAIL rr_repeat_%0d got=%0d prev=%0d", k, obs, prev); end
            total++; if (regaddr !== e.ra) begin bad++; $display("FAIL rr_reg_%0d got=%h exp=%h", k, regaddr, e.ra); end
            prev = obs;
            wait_pulse(1, 300, cyc, ng);
            if (k == 3) req_valid = 2'b00;
            total++; if (req_done !== 2'(1 << e.idx))
                     begin bad++; $display("FAIL rr_done_%0d got=%b exp=%b", k, req_done, 2'(1 << e.idx)); end
            if (e.rw) begin
                total++; if (rd_data !== e.rd) begin bad++; $display("FAIL rr_rd_%0d got=%h exp=%h", k, rd_data, e.rd); end
            end
        end
    endtask

    task automatic test_read();
        int cyc, ng;
        exp_t e;
        model_rd = 8'h96;
        set_req(1, 1'b1, 8'h60, 8'h0A, 8'hFF);
        push_exp(1, 1'b1, 8'h60, 8'h0A, 8'hFF, 8'h96);
        req_valid = 2'b10;
        wait_pulse(0, 20, cyc, ng);
        e = exp_q.pop_front();
        total++; if (req_grant !== 2'b10 || sccb_rw !== 1'b1)
                 begin bad++; $display("FAIL rd_grant got=%b rw=%b exp=10/1", req_grant, sccb_rw); end
        wait_pulse(1, 300, cyc, ng);
        req_valid = 2'b00;
        total++; if (req_done !== 2'b10 || rd_data !== e.rd)
                 begin bad++; $display("FAIL rd_done got=%b data=%h exp=10/%h", req_done, rd_data, e.rd); end
        repeat (5) tick();
        total++; if (rd_data !== 8'h96) begin bad++; $display("FAIL rd_hold got=%h exp=96", rd_data); end
        // A following write must leave rd_data alone even if the master bus data changes.
        model_rd = 8'h33;
        set_req(0, 1'b0, 8'h60, 8'h0B, 8'h01);
        req_valid = 2'b01;
        wait_pulse(0, 20, cyc, ng);
        wait_pulse(1, 300, cyc, ng);
        req_valid = 2'b00;
        total++; if (req_done !== 2'b01 || rd_data !== 8'h96)
                 begin bad++; $display("FAIL rd_after_write got=%b data=%h exp=01/96", req_done, rd_data); end
    endtask

    task automatic test_timeout();
        int cyc, ng;
        model_hang = 1'b1;
        set_req(0, 1'b0, 8'h60, 8'h20, 8'h55);
        req_valid = 2'b01;
        wait_pulse(0, 20, cyc, ng);
        total++; if (req_grant !== 2'b01 || sccb_start !== 1'b1)
                 begin bad++; $display("FAIL to_grant got=%b start=%b exp=01/1", req_grant, sccb_start); end
        wait_pulse(1, 300, cyc, ng);
        req_valid = 2'b00;
        total++; if (req_err !== 2'b01 || req_done !== 2'b00)
                 begin bad++; $display("FAIL to_err got=%b done=%b exp=01/00", req_err, req_done); end
        total++; if (cyc !== TOUT) begin bad++; $display("FAIL to_cycles got=%0d exp=%0d", cyc, TOUT); end
        tick();
        total++; if (sccb_start !== 1'b0 || busy !== 1'b0 || req_err !== 2'b00)
                 begin bad++; $display("FAIL to_after start=%b busy=%b err=%b exp=0/0/00", sccb_start, busy, req_err); end
        model_hang = 1'b0;
        req_valid = 2'b01;
        wait_pulse(0, 20, cyc, ng);
        total++; if (req_grant !== 2'b01) begin bad++; $display("FAIL to_regrant got=%b exp=01", req_grant); end
        wait_pulse(1, 300, cyc, ng);
        req_valid = 2'b00;
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL to_recover_done got=%b exp=01", req_done); end
    endtask

    task automatic test_reset_mid();
        int cyc, ng, seen;
        set_req(0, 1'b0, 8'h61, 8'h30, 8'h77);
        req_valid = 2'b01;
        wait_pulse(0, 20, cyc, ng);
        repeat (10) tick();
        total++; if (busy !== 1'b1 || sccb_start !== 1'b0)
                 begin bad++; $display("FAIL rm_in_wait busy=%b start=%b exp=1/0", busy, sccb_start); end
        rst_n = 1'b0;
        #1;
        total++; if (sccb_start !== 1'b0 || busy !== 1'b0 || (req_grant | req_done | req_err) !== 2'b00)
                 begin bad++; $display("FAIL rm_async start=%b busy=%b pulses=%b/%b/%b exp=0", sccb_start, busy, req_grant, req_done, req_err); end
        req_valid = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if ((req_grant | req_done | req_err) != 0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rm_no_pulse got=%0d exp=0", seen); end
    endtask

    task automatic test_foreign_busy();
        int cyc, ng, seen;
        force_low = 1'b1;
        repeat (2) tick();
        set_req(0, 1'b0, 8'h62, 8'h40, 8'h99);
        req_valid = 2'b01;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_grant != 0 || busy) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL fb_no_grant got=%0d exp=0", seen); end
        force_low = 1'b0;
        wait_pulse(0, 20, cyc, ng);
        total++; if (req_grant !== 2'b01 || devaddr !== 8'h62)
                 begin bad++; $display("FAIL fb_grant got=%b dev=%h exp=01/62", req_grant, devaddr); end
        wait_pulse(1, 300, cyc, ng);
        req_valid = 2'b00;
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL fb_done got=%b exp=01", req_done); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_reset_mid();
        test_foreign_busy();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sccb_master_arbiter
`default_nettype wire
